// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: storage, pointers, occupancy, status and sticky error flags.
// FWFT=0 gives a registered read with one cycle of latency; FWFT=1 presents the head word combinationally.
module sync_fifo_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int AW         = $clog2(FIFO_DEPTH),
    parameter int AFULL_TH   = FIFO_DEPTH - 2,
    parameter int AEMPTY_TH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wen,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_ren,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rvalid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_afull,
    output logic                  o_aempty,
    output logic [AW:0]           o_count,
    output logic                  o_ovf,
    output logic                  o_udf,
    input  logic                  i_clr_err
);

    localparam logic [AW:0] FULL_CNT   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] AFULL_CNT  = (AW + 1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_CNT = (AW + 1)'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [AW:0]           count;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  wr_ok;
    logic                  rd_ok;

    // Handshake: a write is accepted when i_wen is high and the FIFO is not full at the edge;
    // a read is accepted when i_ren is high and it is not empty. There is no full/empty bypass.
    assign wr_ok = i_wen && !o_full;
    assign rd_ok = i_ren && !o_empty;

    assign o_full   = (count == FULL_CNT);
    assign o_empty  = (count == '0);
    assign o_afull  = (count >= AFULL_CNT);
    assign o_aempty = (count <= AEMPTY_CNT);
    assign o_count  = count;
    assign o_ovf    = ovf_q;
    assign o_udf    = udf_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new error in the same cycle as a clear keeps the flag set.
            if (i_wen && o_full)  ovf_q <= 1'b1;
            else if (i_clr_err)   ovf_q <= 1'b0;
            if (i_ren && o_empty) udf_q <= 1'b1;
            else if (i_clr_err)   udf_q <= 1'b0;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[wptr] <= i_wdata;
    end

    generate
        if (FWFT) begin : g_fwft
            assign o_rdata  = mem[rptr];
            assign o_rvalid = !o_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  rvalid_q;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_ok;
                    if (rd_ok) rdata_q <= mem[rptr];
                end
            end
            assign o_rdata  = rdata_q;
            assign o_rvalid = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a standard-read and an FWFT instance share one stimulus stream
// and are compared every cycle against a queue model, plus literal spot checks.
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int DW    = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          wen = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          ren = 1'b0;
    logic          clr = 1'b0;

    logic [DW-1:0] s_rdata, f_rdata;
    logic          s_rvalid, f_rvalid, s_full, f_full, s_empty, f_empty;
    logic          s_afull, f_afull, s_aempty, f_aempty, s_ovf, f_ovf, s_udf, f_udf;
    logic [3:0]    s_count, f_count;

    sync_fifo_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1'b0)) u_std (
        .i_clk(clk), .i_rst(rst), .i_wen(wen), .i_wdata(wdata), .i_ren(ren),
        .o_rdata(s_rdata), .o_rvalid(s_rvalid), .o_full(s_full), .o_empty(s_empty),
        .o_afull(s_afull), .o_aempty(s_aempty), .o_count(s_count),
        .o_ovf(s_ovf), .o_udf(s_udf), .i_clr_err(clr)
    );

    sync_fifo_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1'b1)) u_fwft (
        .i_clk(clk), .i_rst(rst), .i_wen(wen), .i_wdata(wdata), .i_ren(ren),
        .o_rdata(f_rdata), .o_rvalid(f_rvalid), .o_full(f_full), .o_empty(f_empty),
        .o_afull(f_afull), .o_aempty(f_aempty), .o_count(f_count),
        .o_ovf(f_ovf), .o_udf(f_udf), .i_clr_err(clr)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- scoreboard model ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_rdata  = '0;
    logic          m_rvalid = 1'b0;
    logic          m_ovf    = 1'b0;
    logic          m_udf    = 1'b0;

    always @(posedge clk or posedge rst) begin
        int n;
        if (rst) begin
            exp_q.delete();
            m_rdata  = '0;
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
        end else begin
            n = exp_q.size();
            m_rvalid = ren && (n > 0);
            if (m_rvalid) m_rdata = exp_q.pop_front();
            if (wen && n < DEPTH) exp_q.push_back(wdata);
            m_ovf = (wen && n == DEPTH) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_udf = (ren && n == 0)     ? 1'b1 : (clr ? 1'b0 : m_udf);
        end
    end

    always @(negedge clk) begin
        int n;
        if (chk_en) begin
            n = exp_q.size();
            check("s_count",  DW'(s_count),  DW'(n));
            check("f_count",  DW'(f_count),  DW'(n));
            check("s_full",   DW'(s_full),   DW'(n == DEPTH));
            check("f_full",   DW'(f_full),   DW'(n == DEPTH));
            check("s_empty",  DW'(s_empty),  DW'(n == 0));
            check("f_empty",  DW'(f_empty),  DW'(n == 0));
            check("s_afull",  DW'(s_afull),  DW'(n >= DEPTH - 2));
            check("f_afull",  DW'(f_afull),  DW'(n >= DEPTH - 2));
            check("s_aempty", DW'(s_aempty), DW'(n <= 2));
            check("f_aempty", DW'(f_aempty), DW'(n <= 2));
            check("s_ovf",    DW'(s_ovf),    DW'(m_ovf));
            check("f_ovf",    DW'(f_ovf),    DW'(m_ovf));
            check("s_udf",    DW'(s_udf),    DW'(m_udf));
            check("f_udf",    DW'(f_udf),    DW'(m_udf));
            check("s_rvalid", DW'(s_rvalid), DW'(m_rvalid));
            check("s_rdata",  s_rdata,       m_rdata);
            check("f_rvalid", DW'(f_rvalid), DW'(n > 0));
            if (n > 0) check("f_rdata", f_rdata, exp_q[0]);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        wen = w; wdata = d; ren = r; clr = c;
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0; clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        #2 rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty",  DW'(s_empty),  32'd1);
        check("rst_full",   DW'(s_full),   32'd0);
        check("rst_count",  DW'(s_count),  32'd0);
        check("rst_rvalid", DW'(s_rvalid), 32'd0);
        check("rst_rdata",  s_rdata,       32'd0);
        check("rst_ovf",    DW'(s_ovf),    32'd0);
        check("rst_udf",    DW'(s_udf),    32'd0);
        check("rst_frvalid", DW'(f_rvalid), 32'd0);
        rst = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);

        // fill to full, then overflow
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 32'h11 * i, 1'b0, 1'b0);
            if (i == 5) check("afull_at5", DW'(s_afull), 32'd0);
            if (i == 6) check("afull_at6", DW'(s_afull), 32'd1);
        end
        check("full_count", DW'(s_count), 32'd8);
        check("full_flag",  DW'(s_full),  32'd1);
        step(1'b1, 32'hFF, 1'b0, 1'b0);
        check("ovf_set",   DW'(s_ovf),   32'd1);
        check("ovf_count", DW'(s_count), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            check("f_head", f_rdata, 32'h11 * i);
            step(1'b0, '0, 1'b1, 1'b0);
            check("s_rd", s_rdata, 32'h11 * i);
            check("s_rv", DW'(s_rvalid), 32'd1);
        end
        check("drain_empty", DW'(s_empty), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("ovf_clr", DW'(s_ovf), 32'd0);

        // underflow and clear priority
        step(1'b0, '0, 1'b1, 1'b0);
        check("udf_set",    DW'(s_udf),    32'd1);
        check("udf_rvalid", DW'(s_rvalid), 32'd0);
        check("udf_count",  DW'(s_count),  32'd0);
        step(1'b0, '0, 1'b0, 1'b1);
        check("udf_clr", DW'(s_udf), 32'd0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("udf_set_wins", DW'(s_udf), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);

        // pointer wrap with full-throughput streaming
        for (int i = 0; i < 5; i++) step(1'b1, 32'h30 + i, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h103 + i, 1'b1, 1'b0);
            check("stream_data",  s_rdata,        32'h100 + i);
            check("stream_count", DW'(s_count),   32'd3);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("stream_ovf", DW'(s_ovf), 32'd0);
        check("stream_udf", DW'(s_udf), 32'd0);

        // FWFT fall-through
        step(1'b1, 32'hA5, 1'b0, 1'b0);
        check("fwft_rvalid", DW'(f_rvalid), 32'd1);
        check("fwft_rdata",  f_rdata,       32'hA5);
        check("std_norv",    DW'(s_rvalid), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("fwft_pop_rv",    DW'(f_rvalid), 32'd0);
        check("fwft_pop_empty", DW'(f_empty),  32'd1);
        check("std_pop_data",   s_rdata,       32'hA5);

        // full with simultaneous read and write
        for (int i = 0; i < 8; i++) step(1'b1, 32'h200 + i, 1'b0, 1'b0);
        step(1'b1, 32'h2FF, 1'b1, 1'b0);
        check("fullrw_count", DW'(s_count), 32'd7);
        check("fullrw_ovf",   DW'(s_ovf),   32'd1);
        check("fullrw_data",  s_rdata,      32'h200);
        check("fullrw_head",  f_rdata,      32'h201);

        // asynchronous reset mid-burst
        wen = 1'b1; wdata = 32'h300; ren = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_count",  DW'(s_count),  32'd0);
        check("arst_empty",  DW'(s_empty),  32'd1);
        check("arst_full",   DW'(s_full),   32'd0);
        check("arst_rvalid", DW'(s_rvalid), 32'd0);
        check("arst_rdata",  s_rdata,       32'd0);
        check("arst_ovf",    DW'(s_ovf),    32'd0);
        check("arst_frv",    DW'(f_rvalid), 32'd0);
        wen = 1'b0; ren = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 32'h77, 1'b0, 1'b0);
        check("post_count", DW'(s_count), 32'd1);
        check("post_head",  f_rdata,      32'h77);
        step(1'b0, '0, 1'b1, 1'b0);
        check("post_data",  s_rdata,      32'h77);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised synchronous FIFO: a storage array plus read/write pointers, occupancy count, status flags and error flags in one clock domain.
Supports two read modes, selected at elaboration: standard (registered read, one-cycle latency) and first-word-fall-through (FWFT).
Used as the general-purpose buffer between producer and consumer datapaths. Replaces bare memory arrays that need external pointer logic.

Parameters:
FIFO_DEPTH, 8, number of entries; power of two, >= 2
DATA_WIDTH, 32, bits per entry
AW, $clog2(FIFO_DEPTH), pointer width (derived; do not override)
AFULL_TH, FIFO_DEPTH-2, o_afull asserted when count >= AFULL_TH; range 1..FIFO_DEPTH
AEMPTY_TH, 2, o_aempty asserted when count <= AEMPTY_TH; range 0..FIFO_DEPTH-1
FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  asynchronous reset, active-high
i_wen  in  1  write request
i_wdata  in  DATA_WIDTH  write data
i_ren  in  1  read request
o_rdata  out  DATA_WIDTH  read data
o_rvalid  out  1  o_rdata valid
o_full  out  1  count == FIFO_DEPTH
o_empty  out  1  count == 0
o_afull  out  1  count >= AFULL_TH
o_aempty  out  1  count <= AEMPTY_TH
o_count  out  AW+1  current occupancy, 0..FIFO_DEPTH
o_ovf  out  1  sticky overflow: write attempted while full
o_udf  out  1  sticky underflow: read attempted while empty
i_clr_err  in  1  synchronous clear of o_ovf and o_udf

Behaviour:
- Reset (i_rst high, asynchronous): wptr=0, rptr=0, count=0, o_rdata=0, o_rvalid=0, o_ovf=0, o_udf=0. Therefore o_empty=1, o_full=0, o_aempty=1, and o_afull=(AFULL_TH==0 ? 1 : 0), which is 0 for legal AFULL_TH. Array contents are not reset. Reset mid-operation discards all stored data.
- Write accepted (wr_ok) = i_wen && !o_full. On accept: mem[wptr] <= i_wdata and wptr increments. Pointers wrap from FIFO_DEPTH-1 to 0 by natural AW-bit overflow.
- Read accepted (rd_ok) = i_ren && !o_empty. On accept: rptr increments, with the same wrap rule.
- Flags use registered state at the edge. A write to a full FIFO is rejected even if a read is accepted in the same cycle. A read from an empty FIFO is rejected even if a write occurs in the same cycle, so there is no bypass.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- o_full, o_empty, o_afull and o_aempty are combinational decodes of registered count. They are valid in the cycle after the causing edge.
- Standard mode (FWFT=0):
  - On rd_ok, o_rdata <= mem[rptr] and o_rvalid <= 1. Data appears the cycle after the request.
  - Otherwise o_rvalid <= 0 and o_rdata holds its last value.
- FWFT mode (FWFT=1):
  - o_rdata = mem[rptr] combinationally; o_rvalid = !o_empty.
  - A word written into an empty FIFO is visible the cycle after the write.
  - i_ren with o_rvalid high pops the head; the next word is presented in the following cycle.
- Error flags:
  - o_ovf <= 1 on i_wen && o_full; o_udf <= 1 on i_ren && o_empty.
  - i_clr_err clears both flags. A set in the same cycle as the clear wins.
  - Rejected accesses change no other state.
- Full-throughput steady state: when 0 < count < FIFO_DEPTH, simultaneous read and write are sustained at one per cycle indefinitely across pointer wrap.

Test Plan (defaults, FIFO_DEPTH=8, DATA_WIDTH=32, AFULL_TH=6, AEMPTY_TH=2):
- Reset, then idle -> o_empty=1, o_full=0, o_count=0, o_rvalid=0, o_rdata=0, o_ovf=0, o_udf=0.
- FWFT=0: write 0x11..0x88 (8 words) -> o_count=8, o_full=1, o_afull=1 after 6th write. Then 9th write of 0xFF -> o_ovf=1, count stays 8. Then read 8 times -> o_rdata 0x11..0x88, each one cycle after its i_ren, in order; o_empty=1.
- FWFT=0, empty: i_ren=1 -> o_udf=1, o_rvalid=0, count stays 0. i_clr_err=1 for one cycle -> o_udf=0. Clear and underflow in the same cycle -> o_udf=1.
- Wrap: write 5, read 5, then continuous simultaneous read and write of 0x100..0x10F for 16 cycles after preloading 3 words -> o_count constant at 3, data in order, no flag errors.
- FWFT=1: write 0xA5 into empty FIFO -> next cycle o_rvalid=1, o_rdata=0xA5 with no i_ren. Pop -> o_rvalid=0, o_empty=1.
- Full plus simultaneous read and write: count=8, i_wen=i_ren=1 -> read accepted, write rejected, o_ovf=1, o_count=7. Assert i_rst mid-burst -> all outputs return to reset values immediately, without waiting for a clock edge.
